// File: rtl/fetch_gshare_pkg.sv
// Shared types and constants for the gshare fetch stage.
package fetch_gshare_pkg;

  // Width of the history field carried in every fetch packet.
  localparam int PKT_HIST_BITS = 10;

  // Opcodes recognised by the predecoder.
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0]              pc;
    logic [31:0]              instr;
    logic                     prediction;
    logic                     branch;
    logic                     jump;
    logic [PKT_HIST_BITS-1:0] hist;
  } pipe_in_t;

  // Sign-extended B-type immediate.
  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  // Sign-extended J-type immediate.
  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular-buffer packet queue between fetch and decode.
module fetch_queue
  import fetch_gshare_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     push,
  input  logic     pop,
  input  pipe_in_t din,
  output pipe_in_t dout,
  output logic     full,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  pipe_in_t      mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A full queue never accepts, even if the head leaves this same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush drops every queued packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Packet storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_gshare.sv
// Fetch stage with gshare direction predictor and packet queue.
module fetch_gshare
  import fetch_gshare_pkg::*;
#(
  parameter int          IDX_BITS  = 10,
  parameter int          HIST_BITS = 10,
  parameter int          QDEPTH    = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output pipe_in_t             out_pkt,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic [HIST_BITS-1:0] redirect_hist,
  input  logic                 bp_update,
  input  logic                 bp_taken,
  input  logic [31:0]          bp_pc,
  input  logic [HIST_BITS-1:0] bp_hist
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [31:0]          pc;
  logic [HIST_BITS-1:0] hist;
  logic [1:0]           ctr [ENTRIES];

  logic [6:0]           opcode;
  logic                 is_branch;
  logic                 is_jump;
  logic                 prediction;
  logic [31:0]          next_pc;
  logic [IDX_BITS-1:0]  fetch_idx;
  logic [IDX_BITS-1:0]  upd_idx;
  logic [1:0]           upd_next;
  logic                 fetch;
  logic                 deq;
  logic                 q_full;
  logic                 q_empty;
  pipe_in_t             fetch_pkt;
  logic                 unused_bits;

  // Only the word-index bits of the resolved branch PC select a counter.
  assign unused_bits = ^{bp_pc[31:IDX_BITS+2], bp_pc[1:0]};

  assign imem_addr  = pc;
  assign opcode     = imem_data[6:0];
  assign is_branch  = (opcode == OPC_BRANCH);
  assign is_jump    = (opcode == OPC_JAL);
  assign fetch_idx  = pc[IDX_BITS+1:2] ^ IDX_BITS'(hist);
  assign upd_idx    = bp_pc[IDX_BITS+1:2] ^ IDX_BITS'(bp_hist);
  // Counter read is combinational from the flop array, so an update in the
  // same cycle only becomes visible after the edge.
  assign prediction = is_jump | (is_branch & ctr[fetch_idx][1]);
  assign next_pc    = prediction ? pc + (is_jump ? imm_j(imem_data) : imm_b(imem_data))
                                 : pc + 32'd4;

  // Redirect owns the cycle: no fetch, no dequeue.
  assign fetch     = !q_full && !redirect_valid;
  assign deq       = out_valid && out_ready && !redirect_valid;
  assign out_valid = !q_empty;

  always_comb begin
    fetch_pkt            = '0;
    fetch_pkt.pc         = pc;
    fetch_pkt.instr      = imem_data;
    fetch_pkt.prediction = prediction;
    fetch_pkt.branch     = is_branch;
    fetch_pkt.jump       = is_jump;
    fetch_pkt.hist       = PKT_HIST_BITS'(hist);
  end

  // Two-bit saturating counter step for the resolving branch.
  always_comb begin
    upd_next = ctr[upd_idx];
    if (bp_taken) begin
      if (ctr[upd_idx] != 2'b11) upd_next = ctr[upd_idx] + 2'd1;
    end else begin
      if (ctr[upd_idx] != 2'b00) upd_next = ctr[upd_idx] - 2'd1;
    end
  end

  // PC and global history: redirect reload, else advance on each fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc   <= RESET_PC;
      hist <= '0;
    end else if (redirect_valid) begin
      pc   <= redirect_pc;
      hist <= redirect_hist;
    end else if (fetch) begin
      pc <= next_pc;
      if (is_branch) hist <= {hist[HIST_BITS-2:0], prediction};
    end
  end

  // Predictor training, independent of redirects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (bp_update) begin
      ctr[upd_idx] <= upd_next;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (fetch),
    .pop   (deq),
    .din   (fetch_pkt),
    .dout  (out_pkt),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule
